// File: rtl/equiv_miter_monitor.sv
// Equivalence miter: compares y_a (SKEW en-samples late) against y_b after a warm-up period.
// Define EQUIV_MITER_ASSERT_EN to compile a simulation assertion that fires on every compared mismatch.
module equiv_miter_monitor #(
  parameter int WIDTH  = 91,
  parameter int SKEW   = 0,
  parameter int WARMUP = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cyc,
  output logic [CNT_W-1:0] first_cyc,
  output logic [WIDTH-1:0] first_diff
);

  // state     | meaning
  // ST_WARMUP | ignoring samples until WARMUP+SKEW en cycles have elapsed
  // ST_COMPARE| checking every en sample, no mismatch seen yet
  // ST_FAILED | at least one mismatch recorded; still checking
  typedef enum logic [1:0] {
    ST_WARMUP  = 2'b00,
    ST_COMPARE = 2'b01,
    ST_FAILED  = 2'b10
  } state_t;

  localparam int          WARM_N  = WARMUP + SKEW;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [8:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] fcyc_q, fcyc_d;
  logic [WIDTH-1:0] fdiff_q, fdiff_d;
  logic             fail_q, fail_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] y_a_dly;
  logic [WIDTH-1:0] diff;
  logic             neq;
  logic             cmp_mis;
  logic             warm_done;

  generate
    if (SKEW > 0) begin : g_skew
      logic [WIDTH-1:0] sr_q [SKEW];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SKEW; i++) sr_q[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < SKEW; i++) sr_q[i] <= '0;
        end else if (en) begin
          sr_q[0] <= y_a;
          for (int i = 1; i < SKEW; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign y_a_dly = sr_q[SKEW-1];
    end else begin : g_noskew
      assign y_a_dly = y_a;
    end
  endgenerate

  assign diff      = y_a_dly ^ y_b;
  assign warm_done = ({1'b0, wcnt_q} + 10'd1) >= 10'(WARM_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      wcnt_q  <= '0;
      cyc_q   <= '0;
      mcnt_q  <= '0;
      fcyc_q  <= '0;
      fdiff_q <= '0;
      fail_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cyc_q   <= cyc_d;
      mcnt_q  <= mcnt_d;
      fcyc_q  <= fcyc_d;
      fdiff_q <= fdiff_d;
      fail_q  <= fail_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cyc_d   = cyc_q;
    mcnt_d  = mcnt_q;
    fcyc_d  = fcyc_q;
    fdiff_d = fdiff_q;
    fail_d  = fail_q;
    mis_d   = 1'b0;
    cmp_mis = 1'b0;
    // Written as if/else so an X/Z operand lands in the mismatch branch.
    if (y_a_dly == y_b) neq = 1'b0;
    else                neq = 1'b1;

    if (clr) begin
      state_d = ST_WARMUP;
      wcnt_d  = '0;
      cyc_d   = '0;
      mcnt_d  = '0;
      fcyc_d  = '0;
      fdiff_d = '0;
      fail_d  = 1'b0;
    end else if (en) begin
      case (state_q)
        ST_WARMUP: begin
          if (warm_done) state_d = ST_COMPARE;
          else           wcnt_d  = wcnt_q + 9'd1;
        end
        ST_COMPARE, ST_FAILED: begin
          cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_ONE;
          if (neq) begin
            cmp_mis = 1'b1;
            mis_d   = 1'b1;
            mcnt_d  = (&mcnt_q) ? mcnt_q : mcnt_q + CNT_ONE;
            state_d = ST_FAILED;
            fail_d  = 1'b1;
            if (!fail_q) begin
              fcyc_d  = cyc_q;
              fdiff_d = diff;
            end
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  assign state        = state_q;
  assign mismatch     = mis_q;
  assign fail         = fail_q;
  assign mismatch_cnt = mcnt_q;
  assign cyc          = cyc_q;
  assign first_cyc    = fcyc_q;
  assign first_diff   = fdiff_q;

`ifdef EQUIV_MITER_ASSERT_EN
  always @(posedge clk) begin
    if (!rst) begin
      assert (!cmp_mis)
        else $error("equiv_miter_monitor: mismatch at cyc=%0d first_diff=%h",
                    cyc_q, fail_q ? fdiff_q : diff);
    end
  end
`else
  // Checker compiled out; outputs are unaffected either way.
`endif

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// Bench for equiv_miter_monitor: four configurations share stimulus, checked every cycle against a queue model.
module tb_equiv_miter_monitor;

  localparam int NI = 4;
  localparam int SKW [NI] = '{0, 3, 2, 0};
  localparam int THR [NI] = '{2, 5, 4, 2};
  localparam int CMX [NI] = '{65535, 65535, 65535, 15};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic [90:0] y_a = '0;
  logic [90:0] yb [NI];

  logic [1:0]  st_w    [NI];
  logic        mis_w   [NI];
  logic        fail_w  [NI];
  logic [15:0] mcnt_w  [NI];
  logic [15:0] cyc_w   [NI];
  logic [15:0] fcyc_w  [NI];
  logic [90:0] fdiff_w [NI];
  logic [3:0]  mcnt3, cyc3, fcyc3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  equiv_miter_monitor #(.WIDTH(91), .SKEW(0), .WARMUP(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .y_a(y_a), .y_b(yb[0]),
    .state(st_w[0]), .mismatch(mis_w[0]), .fail(fail_w[0]), .mismatch_cnt(mcnt_w[0]),
    .cyc(cyc_w[0]), .first_cyc(fcyc_w[0]), .first_diff(fdiff_w[0]));
  equiv_miter_monitor #(.WIDTH(91), .SKEW(3), .WARMUP(2), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .y_a(y_a), .y_b(yb[1]),
    .state(st_w[1]), .mismatch(mis_w[1]), .fail(fail_w[1]), .mismatch_cnt(mcnt_w[1]),
    .cyc(cyc_w[1]), .first_cyc(fcyc_w[1]), .first_diff(fdiff_w[1]));
  equiv_miter_monitor #(.WIDTH(91), .SKEW(2), .WARMUP(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .y_a(y_a), .y_b(yb[2]),
    .state(st_w[2]), .mismatch(mis_w[2]), .fail(fail_w[2]), .mismatch_cnt(mcnt_w[2]),
    .cyc(cyc_w[2]), .first_cyc(fcyc_w[2]), .first_diff(fdiff_w[2]));
  equiv_miter_monitor #(.WIDTH(91), .SKEW(0), .WARMUP(2), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .y_a(y_a), .y_b(yb[3]),
    .state(st_w[3]), .mismatch(mis_w[3]), .fail(fail_w[3]), .mismatch_cnt(mcnt3),
    .cyc(cyc3), .first_cyc(fcyc3), .first_diff(fdiff_w[3]));

  assign mcnt_w[3] = {12'b0, mcnt3};
  assign cyc_w[3]  = {12'b0, cyc3};
  assign fcyc_w[3] = {12'b0, fcyc3};

  // Model: every en sample since the last reset/clr is kept; sample k is compared
  // once k >= THR, against the y_a recorded SKEW samples earlier.
  logic [90:0] yq [$];
  int          mn = 0;
  int          m_cyc  [NI] = '{0, 0, 0, 0};
  int          m_mcnt [NI] = '{0, 0, 0, 0};
  int          m_fcyc [NI] = '{0, 0, 0, 0};
  bit          m_fail [NI] = '{0, 0, 0, 0};
  bit          m_mis  [NI] = '{0, 0, 0, 0};
  logic [90:0] m_fdiff[NI];

  function automatic void model_clear();
    yq.delete();
    mn = 0;
    for (int i = 0; i < NI; i++) begin
      m_cyc[i] = 0; m_mcnt[i] = 0; m_fcyc[i] = 0;
      m_fail[i] = 0; m_mis[i] = 0; m_fdiff[i] = '0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      model_clear();
    end else if (en) begin
      for (int i = 0; i < NI; i++) begin
        m_mis[i] = 0;
        if (mn >= THR[i]) begin
          logic [90:0] ad;
          ad = (SKW[i] == 0) ? y_a : yq[yq.size() - SKW[i]];
          if (ad != yb[i]) begin
            m_mis[i] = 1;
            if (!m_fail[i]) begin
              m_fcyc[i]  = m_cyc[i];
              m_fdiff[i] = ad ^ yb[i];
              m_fail[i]  = 1;
            end
            if (m_mcnt[i] < CMX[i]) m_mcnt[i] = m_mcnt[i] + 1;
          end
          if (m_cyc[i] < CMX[i]) m_cyc[i] = m_cyc[i] + 1;
        end
      end
      yq.push_back(y_a);
      mn = mn + 1;
    end else begin
      for (int i = 0; i < NI; i++) m_mis[i] = 0;
    end
  end

  function automatic int exp_state(int i);
    if (mn < THR[i]) return 0;
    return m_fail[i] ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [95:0] act, input logic [95:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      if (bad <= 40) $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, inst, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("state",        i, 96'(st_w[i]),   96'(exp_state(i)));
      chk("mismatch",     i, 96'(mis_w[i]),  96'(m_mis[i]));
      chk("fail",         i, 96'(fail_w[i]), 96'(m_fail[i]));
      chk("mismatch_cnt", i, 96'(mcnt_w[i]), 96'(m_mcnt[i]));
      chk("cyc",          i, 96'(cyc_w[i]),  96'(m_cyc[i]));
      chk("first_cyc",    i, 96'(fcyc_w[i]), 96'(m_fcyc[i]));
      chk("first_diff",   i, 96'(fdiff_w[i]), 96'(m_fdiff[i]));
    end
  end

  function automatic logic [90:0] rnd91();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[90:0];
  endfunction

  logic [90:0] hist [$];
  logic [90:0] one90;
  logic [90:0] all1;

  initial begin
    int encount;
    int guard;
    one90 = '0;
    one90[90] = 1'b1;
    all1 = '1;
    for (int i = 0; i < NI; i++) yb[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Phase 1: equal/skewed/inverted streams with 50% en, 100 en samples.
    encount = 0;
    guard = 0;
    while (encount < 100 && guard < 2000) begin
      @(negedge clk);
      guard++;
      en  = 1'($urandom_range(0, 1));
      y_a = rnd91();
      yb[0] = y_a;
      yb[1] = (hist.size() >= 3) ? hist[$-2] : '0;
      yb[2] = yb[1];
      yb[3] = ~y_a;
      if (en) begin
        hist.push_back(y_a);
        encount++;
      end
    end
    chk("en_budget", 0, 96'(encount), 96'(100));
    @(negedge clk);
    en = 1'b0;
    chk("p1_cyc",   0, 96'(cyc_w[0]),  96'(98));
    chk("p1_mcnt",  0, 96'(mcnt_w[0]), 96'(0));
    chk("p1_fail",  0, 96'(fail_w[0]), 96'(0));
    chk("p1_state", 0, 96'(st_w[0]),   96'(1));
    chk("p1_fail",  1, 96'(fail_w[1]), 96'(0));
    chk("p1_cyc",   1, 96'(cyc_w[1]),  96'(95));
    chk("p1_fail",  2, 96'(fail_w[2]), 96'(1));
    chk("p1_mcnt",  3, 96'(mcnt_w[3]), 96'(15));
    chk("p1_cyc",   3, 96'(cyc_w[3]),  96'(15));
    chk("p1_fcyc",  3, 96'(fcyc_w[3]), 96'(0));
    chk("p1_fdiff", 3, 96'(fdiff_w[3]), 96'(all1));

    // Phase 2: clr together with en discards the sample; then flip bit 90 at cyc 10.
    @(negedge clk);
    clr = 1'b1; en = 1'b1; y_a = rnd91();
    yb[0] = ~y_a; yb[1] = y_a; yb[2] = y_a; yb[3] = ~y_a;
    @(negedge clk);
    clr = 1'b0; en = 1'b0;
    chk("clr_state", 0, 96'(st_w[0]),   96'(0));
    chk("clr_cyc",   0, 96'(cyc_w[0]),  96'(0));
    chk("clr_fail",  0, 96'(fail_w[0]), 96'(0));
    chk("clr_mcnt",  3, 96'(mcnt_w[3]), 96'(0));
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 13) chk("pulse_hi", 0, 96'(mis_w[0]), 96'(1));
      if (j == 14) chk("pulse_lo", 0, 96'(mis_w[0]), 96'(0));
      en = 1'b1;
      y_a = rnd91();
      yb[0] = (j == 12) ? (y_a ^ one90) : y_a;
      yb[1] = y_a; yb[2] = y_a; yb[3] = ~y_a;
    end
    @(negedge clk);
    en = 1'b0;
    chk("p2_fcyc",  0, 96'(fcyc_w[0]),  96'(10));
    chk("p2_fdiff", 0, 96'(fdiff_w[0]), 96'(one90));
    chk("p2_fail",  0, 96'(fail_w[0]),  96'(1));
    chk("p2_state", 0, 96'(st_w[0]),    96'(2));
    chk("p2_mcnt",  0, 96'(mcnt_w[0]),  96'(1));
    chk("p2_cyc",   0, 96'(cyc_w[0]),   96'(18));

    // Phase 3: asynchronous reset between edges while FAILED.
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 0, 96'(st_w[0]),    96'(0));
    chk("arst_mis",   0, 96'(mis_w[0]),   96'(0));
    chk("arst_fail",  0, 96'(fail_w[0]),  96'(0));
    chk("arst_mcnt",  0, 96'(mcnt_w[0]),  96'(0));
    chk("arst_cyc",   0, 96'(cyc_w[0]),   96'(0));
    chk("arst_fcyc",  0, 96'(fcyc_w[0]),  96'(0));
    chk("arst_fdiff", 0, 96'(fdiff_w[0]), 96'(0));
    #1 rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      en = 1'b1;
      y_a = rnd91();
      yb[0] = y_a; yb[1] = y_a; yb[2] = y_a; yb[3] = y_a;
    end
    @(negedge clk);
    en = 1'b0;
    chk("p3_cyc",  0, 96'(cyc_w[0]),  96'(8));
    chk("p3_fail", 0, 96'(fail_w[0]), 96'(0));
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
